// File: rtl/ahb_slv_regbank.sv
// rtl/ahb_slv_regbank.sv - AHB-Lite slave with 15 RW registers, a read-only ID word and programmable wait states
module ahb_slv_regbank #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h4D33_0001
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic        HREADYS,
  input  logic [31:0] HWDATAS,
  output logic        HREADYOUTS,
  output logic        HRESPS,
  output logic [31:0] HRDATAS
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d;
  logic        dp_q, dp_d;
  logic [31:0] regs_q [0:14];
  logic [31:0] regs_d [0:14];

  logic        valid, xfer_err, accept, complete;
  logic [3:0]  lanes;
  logic [31:0] rd_word;
  logic        unused_ok;

  assign unused_ok = ^{HADDRS[31:6], HTRANSS[0]};

  assign valid    = HSELS & HTRANSS[1] & HREADYS;
  assign xfer_err = (HSIZES > 3'd2) ||
                    (HSIZES == 3'd1 && HADDRS[0]) ||
                    (HSIZES == 3'd2 && HADDRS[1:0] != 2'b00) ||
                    (HWRITES && HADDRS[5:2] == 4'hF);
  assign accept   = valid && (state_q == S_IDLE || state_q == S_ERR2);
  // dp_q marks an OKAY data phase; it completes in the first IDLE cycle after WAIT
  assign complete = dp_q && (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    dp_d    = dp_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_IDLE;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        dp_d    = 1'b0;
        if (accept) begin
          addr_d  = HADDRS[5:0];
          size_d  = HSIZES[1:0];
          write_d = HWRITES;
          if (xfer_err) begin
            state_d = S_ERR1;
          end else begin
            dp_d = 1'b1;
            if (WAIT_STATES != 0) begin
              state_d = S_WAIT;
              cnt_d   = 4'(WAIT_STATES);
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0:    lanes = 4'b0001 << addr_q[1:0];
      2'd1:    lanes = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (complete && write_q && addr_q[5:2] != 4'hF) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes[b]) regs_d[addr_q[5:2]][8*b +: 8] = HWDATAS[8*b +: 8];
      end
    end
  end

  assign rd_word    = (addr_q[5:2] == 4'hF) ? ID_VALUE : regs_q[addr_q[5:2]];
  assign HREADYOUTS = !(state_q == S_WAIT || state_q == S_ERR1);
  assign HRESPS     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign HRDATAS    = (complete && !write_q) ? rd_word : 32'h0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 6'd0;
      size_q  <= 2'd0;
      write_q <= 1'b0;
      dp_q    <= 1'b0;
      for (int i = 0; i < 15; i++) regs_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
      dp_q    <= dp_d;
      regs_q  <= regs_d;
    end
  end
endmodule

// File: doc/ahb_slv_regbank.md
AHB_SLV_REGBANK -- requirements
Module: ahb_slv_regbank

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, number of data-phase wait cycles per valid OKAY transfer (legal range 0..15).
REQ-002 SHALL have parameter ID_VALUE, default 32'h4D33_0001, constant returned by register 15.
REQ-003 SHALL have input HCLK, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have input HRESETn, 1 bit, reset; asynchronous assertion, active-low.
REQ-005 SHALL have input HSELS, 1 bit, slave select.
REQ-006 SHALL have input HADDRS, 32 bits, address; bits [5:0] decoded, bits [31:6] ignored.
REQ-007 SHALL have input HTRANSS, 2 bits, transfer type.
REQ-008 SHALL have input HWRITES, 1 bit, write when 1.
REQ-009 SHALL have input HSIZES, 3 bits, transfer size.
REQ-010 SHALL have input HREADYS, 1 bit, bus HREADY (mux output) from the interconnect.
REQ-011 SHALL have input HWDATAS, 32 bits, write data, valid in the data phase.
REQ-012 SHALL have output HREADYOUTS, 1 bit, slave ready.
REQ-013 SHALL have output HRESPS, 1 bit, 0 = OKAY, 1 = ERROR.
REQ-014 SHALL have output HRDATAS, 32 bits, read data.

Function
REQ-015 A valid address phase SHALL be HSELS & HTRANSS[1] & HREADYS at a rising edge; on it, HADDRS[5:0], HWRITES and HSIZES SHALL be registered.
REQ-016 IDLE/BUSY transfers and unselected cycles SHALL give zero-wait OKAY and SHALL NOT change any register.
REQ-017 A transfer SHALL be an error if any of these holds: HSIZES > 2; size 1 with addr[0]=1; size 2 with addr[1:0]≠0; a write to register 15.
REQ-018 The FSM SHALL have four states: IDLE, WAIT, ERR1, ERR2.
REQ-019 IDLE: on a valid error transfer, go to ERR1; on a valid OKAY transfer with WAIT_STATES>0, go to WAIT and load the wait counter with WAIT_STATES; otherwise stay in IDLE.
REQ-020 WAIT: HREADYOUTS=0; the counter decrements each cycle; when it reaches 1 the next cycle is the completing cycle (HREADYOUTS=1), giving exactly WAIT_STATES low cycles.
REQ-021 ERR1: HREADYOUTS=0, HRESPS=1 for one cycle, then ERR2.
REQ-022 ERR2: HREADYOUTS=1, HRESPS=1 for one cycle; a valid address phase sampled in this cycle SHALL be accepted as in IDLE.
REQ-023 The completing OKAY cycle (HREADYOUTS=1) SHALL accept a back-to-back address phase with no idle cycle.
REQ-024 The register file SHALL be registers 0..14 at 32 bits (index = addr[5:2]); register 15 SHALL be read-only ID_VALUE.
REQ-025 Write byte lanes, little-endian: size 0 enables lane addr[1:0]; size 1 enables lanes {1,0} or {3,2} by addr[1]; size 2 enables all four lanes.
REQ-026 Write data SHALL be taken from HWDATAS and committed at the edge ending the completing cycle only; errored writes SHALL commit nothing.
REQ-027 HRDATAS SHALL hold the full 32-bit register word during the completing cycle of a read and SHALL be 0 in all other cycles, including error cycles.
REQ-028 A read immediately following a write to the same register SHALL return the newly written value.

Reset
REQ-029 While HRESETn=0: FSM in IDLE, wait counter 0, registers 0..14 = 0, HREADYOUTS=1, HRESPS=0, HRDATAS=0.
REQ-030 Reset asserted mid-transfer (WAIT/ERR1/ERR2) SHALL abort immediately; a pending write SHALL NOT commit.

Verification
REQ-031 WAIT_STATES=1: write 0x1234_5678 to 0x08 (size 2), then read 0x08 -> write data phase HREADYOUTS low 1 cycle; read returns 0x1234_5678.
REQ-032 Byte write 0xAB to 0x05 (size 0, HWDATAS=0x0000_AB00), then read 0x04 -> 0x0000_AB00.
REQ-033 Write to 0x3C, then read 0x3C -> first transfer: ERR1 (READY=0, RESP=1), ERR2 (READY=1, RESP=1); read returns ID_VALUE with OKAY.
REQ-034 Size-2 read at 0x02 -> two-cycle ERROR; HRDATAS=0 throughout.
REQ-035 WAIT_STATES=0: back-to-back writes to 0x00, 0x04, 0x08 with HTRANSS=NONSEQ/SEQ -> HREADYOUTS never low; all three registers updated.
REQ-036 HRESETn pulsed low during WAIT of a write to 0x10 -> outputs return to reset values; a later read of 0x10 returns 0.
